branch_predictor_btb: RTL and testbench

//   Parametrised branch target buffer with per-entry saturating direction counters for the 5-stage RV32I pipeline.
//   IF stage looks up the fetch PC combinationally to obtain a predicted next PC. EX stage reports the resolved outcome.
//   The block updates its table and flags a mispredict with the corrected PC; the pipeline flushes IF/ID and ID/EX only then.

---
 rtl/branch_predictor_btb_pkg.sv | 23 ++
 rtl/branch_predictor_btb_sat_counter.sv | 23 ++
 rtl/branch_predictor_btb.sv | 115 +++++++++++
 tb/tb_branch_predictor_btb.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_btb_pkg.sv
// Shared definitions for the branch target buffer: counter encodings and
// the per-update table action decoded from the resolved branch.
package branch_predictor_btb_pkg;

  // Saturation ceiling of a counter of the given width.
  function automatic int ctr_max(input int bits);
    return (1 << bits) - 1;
  endfunction

  // Weakly-taken: MSB set, all lower bits clear.
  function automatic int ctr_weak_taken(input int bits);
    return 1 << (bits - 1);
  endfunction

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_HIT_JUMP,
    ACT_HIT_TAKEN,
    ACT_HIT_NT,
    ACT_ALLOC
  } tbl_act_e;

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// Combinational next-value for one saturating direction counter.
// Priority: load, then set-max, then increment, then decrement.
module branch_predictor_btb_sat_counter #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] cur,
  input  logic                inc,
  input  logic                dec,
  input  logic                set_max,
  input  logic                load,
  input  logic [CTR_BITS-1:0] load_val,
  output logic [CTR_BITS-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (load)                     nxt = load_val;
    else if (set_max)             nxt = '1;
    else if (inc && (cur != '1))  nxt = cur + CTR_BITS'(1);
    else if (dec && (cur != '0))  nxt = cur - CTR_BITS'(1);
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry direction counters: combinational IF-stage
// lookup, EX-stage update, mispredict/redirect generation and perf counters.
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] LKP_PC,
  output logic            PRED_TAKEN,
  output logic [XLEN-1:0] PRED_TARGET,
  input  logic            UPD_VALID,
  input  logic            UPD_IS_JUMP,
  input  logic [XLEN-1:0] UPD_PC,
  input  logic            UPD_TAKEN,
  input  logic [XLEN-1:0] UPD_TARGET,
  input  logic            UPD_PRED_TAKEN,
  input  logic [XLEN-1:0] UPD_PRED_TARGET,
  output logic            MISPREDICT,
  output logic [XLEN-1:0] REDIRECT_PC,
  output logic [31:0]     BR_COUNT,
  output logic [31:0]     MISS_COUNT
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_LO   = IDX_BITS + 2;
  localparam int TAG_HI   = IDX_BITS + TAG_BITS + 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = CTR_BITS'(ctr_max(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(ctr_weak_taken(CTR_BITS));

  logic [ENTRIES-1:0]                valid_q;
  logic [ENTRIES-1:0][TAG_BITS-1:0]  tag_q;
  logic [ENTRIES-1:0][XLEN-1:0]      target_q;
  logic [ENTRIES-1:0][CTR_BITS-1:0]  ctr_q;

  logic [IDX_BITS-1:0] lkp_idx, upd_idx;
  logic [TAG_BITS-1:0] lkp_tag, upd_tag;
  logic                lkp_hit, upd_hit, upd_taken_eff;
  logic [CTR_BITS-1:0] ctr_nxt;
  tbl_act_e            act;

  // PC[1:0] and bits above the tag never select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{LKP_PC, UPD_PC};

  assign lkp_idx = LKP_PC[IDX_BITS+1:2];
  assign lkp_tag = LKP_PC[TAG_HI:TAG_LO];
  assign upd_idx = UPD_PC[IDX_BITS+1:2];
  assign upd_tag = UPD_PC[TAG_HI:TAG_LO];

  assign lkp_hit = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Reads come straight from the flops, so a same-cycle update is invisible.
  assign PRED_TAKEN  = !RESET && lkp_hit && ctr_q[lkp_idx][CTR_BITS-1];
  assign PRED_TARGET = PRED_TAKEN ? target_q[lkp_idx] : LKP_PC + XLEN'(4);

  assign MISPREDICT  = !RESET && UPD_VALID &&
                       ((UPD_TAKEN != UPD_PRED_TAKEN) ||
                        (UPD_TAKEN && (UPD_PRED_TARGET != UPD_TARGET)));
  assign REDIRECT_PC = UPD_TAKEN ? UPD_TARGET : UPD_PC + XLEN'(4);

  assign upd_taken_eff = UPD_TAKEN || UPD_IS_JUMP;

  always_comb begin
    act = ACT_NONE;
    if (UPD_VALID) begin
      if (upd_hit) begin
        if (UPD_IS_JUMP)    act = ACT_HIT_JUMP;
        else if (UPD_TAKEN) act = ACT_HIT_TAKEN;
        else                act = ACT_HIT_NT;
      end else if (upd_taken_eff) begin
        act = ACT_ALLOC;
      end
    end
  end

  branch_predictor_btb_sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
    .cur      (ctr_q[upd_idx]),
    .inc      (act == ACT_HIT_TAKEN),
    .dec      (act == ACT_HIT_NT),
    .set_max  (act == ACT_HIT_JUMP),
    .load     (act == ACT_ALLOC),
    .load_val (UPD_IS_JUMP ? CTR_MAX : CTR_WEAK),
    .nxt      (ctr_nxt)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q    <= '0;
      tag_q      <= '0;
      target_q   <= '0;
      ctr_q      <= '0;
      BR_COUNT   <= '0;
      MISS_COUNT <= '0;
    end else begin
      if (act != ACT_NONE) ctr_q[upd_idx] <= ctr_nxt;
      if (act == ACT_HIT_JUMP || act == ACT_HIT_TAKEN || act == ACT_ALLOC)
        target_q[upd_idx] <= UPD_TARGET;
      if (act == ACT_ALLOC) begin
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
      end
      if (UPD_VALID && (BR_COUNT != 32'hFFFF_FFFF))
        BR_COUNT <= BR_COUNT + 32'd1;
      if (MISPREDICT && (MISS_COUNT != 32'hFFFF_FFFF))
        MISS_COUNT <= MISS_COUNT + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: reset, allocation, counter
// saturation, aliasing, jump retargeting and same-cycle/reset corners.
module tb_branch_predictor_btb;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] LKP_PC;
  logic        PRED_TAKEN;
  logic [31:0] PRED_TARGET;
  logic        UPD_VALID, UPD_IS_JUMP, UPD_TAKEN, UPD_PRED_TAKEN;
  logic [31:0] UPD_PC, UPD_TARGET, UPD_PRED_TARGET;
  logic        MISPREDICT;
  logic [31:0] REDIRECT_PC, BR_COUNT, MISS_COUNT;

  int checks = 0;
  int errors = 0;

  branch_predictor_btb dut (
    .CLK(CLK), .RESET(RESET), .LKP_PC(LKP_PC),
    .PRED_TAKEN(PRED_TAKEN), .PRED_TARGET(PRED_TARGET),
    .UPD_VALID(UPD_VALID), .UPD_IS_JUMP(UPD_IS_JUMP), .UPD_PC(UPD_PC),
    .UPD_TAKEN(UPD_TAKEN), .UPD_TARGET(UPD_TARGET),
    .UPD_PRED_TAKEN(UPD_PRED_TAKEN), .UPD_PRED_TARGET(UPD_PRED_TARGET),
    .MISPREDICT(MISPREDICT), .REDIRECT_PC(REDIRECT_PC),
    .BR_COUNT(BR_COUNT), .MISS_COUNT(MISS_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_upd(input logic jump, input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
    UPD_VALID = 1'b1; UPD_IS_JUMP = jump; UPD_PC = pc; UPD_TAKEN = taken;
    UPD_TARGET = tgt; UPD_PRED_TAKEN = ptaken; UPD_PRED_TARGET = ptgt;
    #1;
  endtask

  task automatic clear_upd();
    UPD_VALID = 1'b0; UPD_IS_JUMP = 1'b0; UPD_TAKEN = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    LKP_PC = 32'h100; #1;
    checks++; if (PRED_TAKEN !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %0b exp 0", PRED_TAKEN); end
    checks++; if (PRED_TARGET !== 32'h104) begin errors++; $display("FAIL reset_pred_target got %h exp 104", PRED_TARGET); end
    checks++; if (BR_COUNT !== 32'd0) begin errors++; $display("FAIL reset_br_count got %0d exp 0", BR_COUNT); end
    checks++; if (MISS_COUNT !== 32'd0) begin errors++; $display("FAIL reset_miss_count got %0d exp 0", MISS_COUNT); end
    checks++; if (MISPREDICT !== 1'b0) begin errors++; $display("FAIL idle_mispredict got %0b exp 0", MISPREDICT); end
  endtask

  task automatic test_alloc();
    drive_upd(1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    checks++; if (MISPREDICT !== 1'b1) begin errors++; $display("FAIL alloc_mispredict got %0b exp 1", MISPREDICT); end
    checks++; if (REDIRECT_PC !== 32'h80) begin errors++; $display("FAIL alloc_redirect got %h exp 80", REDIRECT_PC); end
    tick(); clear_upd();
    checks++; if (PRED_TAKEN !== 1'b1) begin errors++; $display("FAIL alloc_pred_taken got %0b exp 1", PRED_TAKEN); end
    checks++; if (PRED_TARGET !== 32'h80) begin errors++; $display("FAIL alloc_pred_target got %h exp 80", PRED_TARGET); end
    checks++; if (MISS_COUNT !== 32'd1) begin errors++; $display("FAIL alloc_miss_count got %0d exp 1", MISS_COUNT); end
    checks++; if (BR_COUNT !== 32'd1) begin errors++; $display("FAIL alloc_br_count got %0d exp 1", BR_COUNT); end
  endtask

  task automatic test_saturation();
    LKP_PC = 32'h100;
    for (int i = 0; i < 3; i++) begin
      drive_upd(1'b0, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      checks++; if (MISPREDICT !== 1'b0) begin errors++; $display("FAIL sat_taken_mispredict[%0d] got %0b exp 0", i, MISPREDICT); end
      tick();
    end
    // ctr is 3; first not-taken drops it to 2
    drive_upd(1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    checks++; if (MISPREDICT !== 1'b1) begin errors++; $display("FAIL sat_nt_mispredict got %0b exp 1", MISPREDICT); end
    checks++; if (REDIRECT_PC !== 32'h104) begin errors++; $display("FAIL sat_nt_redirect got %h exp 104", REDIRECT_PC); end
    tick(); clear_upd();
    checks++; if (PRED_TAKEN !== 1'b1) begin errors++; $display("FAIL sat_ctr2_pred got %0b exp 1", PRED_TAKEN); end
    drive_upd(1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    tick(); clear_upd();
    checks++; if (PRED_TAKEN !== 1'b0) begin errors++; $display("FAIL sat_ctr1_pred got %0b exp 0", PRED_TAKEN); end
    checks++; if (PRED_TARGET !== 32'h104) begin errors++; $display("FAIL sat_ctr1_target got %h exp 104", PRED_TARGET); end
    // two more not-taken must floor at 0, then one taken gives 1 (still not-taken)
    for (int i = 0; i < 2; i++) begin
      drive_upd(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
      checks++; if (MISPREDICT !== 1'b0) begin errors++; $display("FAIL sat_floor_mispredict[%0d] got %0b exp 0", i, MISPREDICT); end
      tick();
    end
    drive_upd(1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick(); clear_upd();
    checks++; if (PRED_TAKEN !== 1'b0) begin errors++; $display("FAIL sat_floor_pred got %0b exp 0", PRED_TAKEN); end
    checks++; if (BR_COUNT !== 32'd9) begin errors++; $display("FAIL sat_br_count got %0d exp 9", BR_COUNT); end
    checks++; if (MISS_COUNT !== 32'd4) begin errors++; $display("FAIL sat_miss_count got %0d exp 4", MISS_COUNT); end
  endtask

  task automatic test_alias();
    LKP_PC = 32'h140; #1;
    checks++; if (PRED_TAKEN !== 1'b0) begin errors++; $display("FAIL alias_miss_pred got %0b exp 0", PRED_TAKEN); end
    checks++; if (PRED_TARGET !== 32'h144) begin errors++; $display("FAIL alias_miss_target got %h exp 144", PRED_TARGET); end
    drive_upd(1'b0, 32'h140, 1'b1, 32'h40, 1'b0, 32'h144);
    tick(); clear_upd();
    checks++; if (PRED_TAKEN !== 1'b1 || PRED_TARGET !== 32'h40) begin errors++; $display("FAIL alias_new_entry got %0b/%h exp 1/40", PRED_TAKEN, PRED_TARGET); end
    LKP_PC = 32'h100; #1;
    checks++; if (PRED_TAKEN !== 1'b0 || PRED_TARGET !== 32'h104) begin errors++; $display("FAIL alias_evicted got %0b/%h exp 0/104", PRED_TAKEN, PRED_TARGET); end
  endtask

  task automatic test_jalr();
    LKP_PC = 32'h204;
    drive_upd(1'b1, 32'h204, 1'b1, 32'h200, 1'b0, 32'h208);
    tick(); clear_upd();
    checks++; if (PRED_TAKEN !== 1'b1 || PRED_TARGET !== 32'h200) begin errors++; $display("FAIL jal_alloc got %0b/%h exp 1/200", PRED_TAKEN, PRED_TARGET); end
    drive_upd(1'b1, 32'h204, 1'b1, 32'h300, 1'b1, 32'h200);
    checks++; if (MISPREDICT !== 1'b1) begin errors++; $display("FAIL jalr_mispredict got %0b exp 1", MISPREDICT); end
    checks++; if (REDIRECT_PC !== 32'h300) begin errors++; $display("FAIL jalr_redirect got %h exp 300", REDIRECT_PC); end
    tick(); clear_upd();
    checks++; if (PRED_TARGET !== 32'h300) begin errors++; $display("FAIL jalr_new_target got %h exp 300", PRED_TARGET); end
    drive_upd(1'b1, 32'h204, 1'b1, 32'h300, 1'b1, 32'h300);
    checks++; if (MISPREDICT !== 1'b0) begin errors++; $display("FAIL jalr_correct got %0b exp 0", MISPREDICT); end
    tick(); clear_upd();
    checks++; if (BR_COUNT !== 32'd13 || MISS_COUNT !== 32'd7) begin errors++; $display("FAIL jalr_counts got %0d/%0d exp 13/7", BR_COUNT, MISS_COUNT); end
  endtask

  task automatic test_same_cycle();
    // 0x140 entry sits at ctr 2; a not-taken update drops it to 1
    LKP_PC = 32'h140;
    drive_upd(1'b0, 32'h140, 1'b0, 32'h0, 1'b1, 32'h40);
    checks++; if (PRED_TAKEN !== 1'b1 || PRED_TARGET !== 32'h40) begin errors++; $display("FAIL same_cycle_old got %0b/%h exp 1/40", PRED_TAKEN, PRED_TARGET); end
    tick(); clear_upd();
    checks++; if (PRED_TAKEN !== 1'b0 || PRED_TARGET !== 32'h144) begin errors++; $display("FAIL same_cycle_new got %0b/%h exp 0/144", PRED_TAKEN, PRED_TARGET); end
  endtask

  task automatic test_reset_update();
    LKP_PC = 32'h204;
    RESET = 1'b1;
    drive_upd(1'b0, 32'h300, 1'b1, 32'h500, 1'b0, 32'h304);
    checks++; if (PRED_TAKEN !== 1'b0 || PRED_TARGET !== 32'h208) begin errors++; $display("FAIL during_reset_pred got %0b/%h exp 0/208", PRED_TAKEN, PRED_TARGET); end
    tick();
    RESET = 1'b0; clear_upd();
    checks++; if (PRED_TAKEN !== 1'b0) begin errors++; $display("FAIL reset_cleared_entry got %0b exp 0", PRED_TAKEN); end
    LKP_PC = 32'h300; #1;
    checks++; if (PRED_TAKEN !== 1'b0 || PRED_TARGET !== 32'h304) begin errors++; $display("FAIL reset_no_alloc got %0b/%h exp 0/304", PRED_TAKEN, PRED_TARGET); end
    checks++; if (BR_COUNT !== 32'd0 || MISS_COUNT !== 32'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", BR_COUNT, MISS_COUNT); end
    // table must really be empty: a taken update on 0x300 allocates weakly taken
    drive_upd(1'b0, 32'h300, 1'b1, 32'h500, 1'b0, 32'h304);
    tick(); clear_upd();
    checks++; if (PRED_TAKEN !== 1'b1 || PRED_TARGET !== 32'h500) begin errors++; $display("FAIL post_reset_alloc got %0b/%h exp 1/500", PRED_TAKEN, PRED_TARGET); end
  endtask

  initial begin
    RESET = 1'b1; LKP_PC = 32'h0;
    UPD_VALID = 1'b0; UPD_IS_JUMP = 1'b0; UPD_PC = 32'h0; UPD_TAKEN = 1'b0;
    UPD_TARGET = 32'h0; UPD_PRED_TAKEN = 1'b0; UPD_PRED_TARGET = 32'h0;
    tick(); tick();
    RESET = 1'b0;
    test_reset();
    test_alloc();
    test_saturation();
    test_alias();
    test_jalr();
    test_same_cycle();
    test_reset_update();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
